// File: rtl/align_pkg.sv
// Shared definitions for the alignment-link width converters (serializer and
// the receive-side deserializer).
package align_pkg;

    // Serializer FSM encoding; the numeric values are fixed so that debug
    // probes and the companion deserializer agree on them.
    typedef enum logic {
        ALIGN_SER_IDLE = 1'b0,
        ALIGN_SER_SEND = 1'b1
    } align_ser_state_e;

    // Ceiling log2, usable in constant expressions for sizing counters.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/align_flit_serializer_if.sv
// Bundle of the wide-word input side and the beat output side of the
// serializer. Signal names follow the serializer's point of view.
//
// Handshake (both sides): a transfer happens on a rising edge iff
// valid & ~stall. A producer that raises valid keeps valid and data stable
// until that transfer happens. i_* signals flow into the serializer,
// o_* signals flow out of it (o_stall is the input-side back-pressure,
// i_stall is the output-side back-pressure from the link FIFO).
interface align_flit_serializer_if #(
    parameter int N     = 32,
    parameter int BEATS = 4
);
    logic [N*BEATS-1:0] i_data;
    logic               i_valid;
    logic               o_stall;
    logic [N-1:0]       o_data;
    logic               o_valid;
    logic               o_last;
    logic               i_stall;

    // Driver of the serializer (upstream producer plus downstream FIFO).
    modport master (
        output i_data, i_valid, i_stall,
        input  o_stall, o_data, o_valid, o_last
    );

    // The serializer itself.
    modport slave (
        input  i_data, i_valid, i_stall,
        output o_stall, o_data, o_valid, o_last
    );
endinterface

// File: rtl/align_flit_serializer.sv
// Transmit-side width converter: takes one BEATS*N-bit word and emits it as
// BEATS N-bit beats, least-significant beat first, marking the final beat.
// The last beat's consumption and the next word's acceptance share one edge,
// so a continuous stream has no bubble between words.
module align_flit_serializer
    import align_pkg::*;
#(
    parameter int N     = 32,
    parameter int BEATS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    align_flit_serializer_if.slave  bus,
    output align_ser_state_e        dbg_state
);

    // Beat counter needs at least one bit even when BEATS is 1.
    localparam int BW = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    align_ser_state_e     state_q, state_d;
    logic [N*BEATS-1:0]   word_q, word_d;
    logic [BW-1:0]        beat_q, beat_d;

    logic                 is_send;
    logic                 is_last;
    logic                 consume;
    logic                 accept;
    logic                 stall_w;

    // Next-state, handshake decode and counter update.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        beat_d  = beat_q;

        is_send = (state_q == ALIGN_SER_SEND);
        is_last = (beat_q == LAST_BEAT);
        consume = is_send & ~bus.i_stall;
        // Input is free in IDLE, or in SEND only when the last beat leaves
        // this cycle; reset holds it off so nothing is taken mid-reset.
        stall_w = ~rst_n | (is_send & ~(consume & is_last));
        accept  = bus.i_valid & ~stall_w;

        if (accept) begin
            word_d  = bus.i_data;
            beat_d  = '0;
            state_d = ALIGN_SER_SEND;
        end else if (consume) begin
            if (is_last) begin
                state_d = ALIGN_SER_IDLE;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    // State, held word and beat index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ALIGN_SER_IDLE;
            beat_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
        end
    end

    assign bus.o_stall = stall_w;
    assign bus.o_valid = is_send;
    assign bus.o_last  = is_send & is_last;
    assign bus.o_data  = word_q[beat_q*N +: N];
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_align_flit_serializer.sv
// Directed and seeded-random checks for the flit serializer, covering the
// BEATS=4 configuration and a BEATS=1 pass-through instance.
module tb_align_flit_serializer;
    import align_pkg::*;

    localparam int N     = 32;
    localparam int BEATS = 4;
    localparam int W     = N * BEATS;

    localparam logic [W-1:0] W1 = 128'h44444444_33333333_22222222_11111111;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    align_flit_serializer_if #(.N(N), .BEATS(BEATS)) bus ();
    align_flit_serializer_if #(.N(N), .BEATS(1))     bus1 ();

    align_ser_state_e dbg_state;
    align_ser_state_e dbg_state1;

    align_flit_serializer #(.N(N), .BEATS(BEATS)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    align_flit_serializer #(.N(N), .BEATS(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .dbg_state (dbg_state1)
    );

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    function automatic logic [N-1:0] beat_of(input logic [W-1:0] w, input int k);
        logic [W-1:0] t;
        t = w >> (k * N);
        return t[N-1:0];
    endfunction

    // Reset with valid held high, then first word taken on the first free edge.
    task automatic test_reset();
        rst_n        = 1'b0;
        bus.i_valid  = 1'b1;
        bus.i_data   = W1;
        bus.i_stall  = 1'b0;
        bus1.i_valid = 1'b0;
        bus1.i_data  = '0;
        bus1.i_stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if (bus.o_stall !== 1'b1) begin
                errors++;
                $display("FAIL reset_stall cycle %0d got %b exp 1", c, bus.o_stall);
            end
        end
        rst_n = 1'b1; #1;
        checks++;
        if (bus.o_stall !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_last !== 1'b0) begin
            errors++;
            $display("FAIL post_reset stall/valid/last got %b%b%b exp 000",
                     bus.o_stall, bus.o_valid, bus.o_last);
        end
        checks++;
        if (dbg_state !== ALIGN_SER_IDLE) begin
            errors++;
            $display("FAIL post_reset_state got %0d exp 0", dbg_state);
        end
        for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1;
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== beat_of(W1, k)) begin
                errors++;
                $display("FAIL reset_first_word beat %0d got v=%b d=%h exp v=1 d=%h",
                         k, bus.o_valid, bus.o_data, beat_of(W1, k));
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_word_drain valid got %b exp 0", bus.o_valid);
        end
    endtask

    // One word with no back-pressure: four beats, last only on the fourth.
    task automatic test_single_word();
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = W1;
        bus.i_stall = 1'b0;
        #1;
        checks++;
        if (bus.o_stall !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_stall got %b exp 0", bus.o_stall);
        end
        for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1;
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== beat_of(W1, k) ||
                bus.o_last !== (k == BEATS - 1)) begin
                errors++;
                $display("FAIL single_beat %0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         k, bus.o_valid, bus.o_data, bus.o_last, beat_of(W1, k), (k == BEATS - 1));
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0) begin
            errors++;
            $display("FAIL single_after valid/last got %b%b exp 00", bus.o_valid, bus.o_last);
        end
    endtask

    // Two words with continuous valid: eight beats, no bubble between words.
    task automatic test_back_to_back();
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        logic [W-1:0] wexp;
        wa = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;
        wb = 128'hB7B7B7B3_B7B7B7B2_B7B7B7B1_B7B7B7B0;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = wa;
        bus.i_stall = 1'b0;
        #1;
        for (int c = 0; c < 2 * BEATS; c++) begin
            @(negedge clk);
            if (c < BEATS) begin
                bus.i_valid = 1'b1;
                bus.i_data  = wb;
            end else begin
                bus.i_valid = 1'b0;
            end
            #1;
            wexp = (c < BEATS) ? wa : wb;
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== beat_of(wexp, c % BEATS) ||
                bus.o_last !== ((c % BEATS) == BEATS - 1)) begin
                errors++;
                $display("FAIL b2b_beat %0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         c, bus.o_valid, bus.o_data, bus.o_last,
                         beat_of(wexp, c % BEATS), ((c % BEATS) == BEATS - 1));
            end
            if (c < BEATS) begin
                checks++;
                if (bus.o_stall !== (c != BEATS - 1)) begin
                    errors++;
                    $display("FAIL b2b_stall cycle %0d got %b exp %b", c, bus.o_stall, (c != BEATS - 1));
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_after valid got %b exp 0", bus.o_valid);
        end
    endtask

    // 200 random words under 50% random downstream stall, scoreboarded.
    task automatic test_random_stall();
        int           sent;
        int           lasts;
        int           beat_idx;
        int           cyc;
        logic         pending;
        logic         prev_hold;
        logic [N-1:0] prev_data;
        logic [N-1:0] exp_b;
        logic [W-1:0] word;
        sent      = 0;
        lasts     = 0;
        beat_idx  = 0;
        cyc       = 0;
        pending   = 1'b0;
        prev_hold = 1'b0;
        prev_data = '0;
        word      = '0;
        void'($urandom(32'd2024));
        exp_q.delete();
        while ((sent < 200 || exp_q.size() != 0 || pending) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            bus.i_stall = ($urandom_range(0, 1) == 1);
            if (!pending && sent < 200 && $urandom_range(0, 3) != 0) begin
                for (int k = 0; k < BEATS; k++) word[k*N +: N] = $urandom;
                pending = 1'b1;
            end
            bus.i_valid = pending;
            bus.i_data  = word;
            #1;
            if (prev_hold) begin
                checks++;
                if (bus.o_valid !== 1'b1 || bus.o_data !== prev_data) begin
                    errors++;
                    $display("FAIL rand_hold cycle %0d got v=%b d=%h exp v=1 d=%h",
                             cyc, bus.o_valid, bus.o_data, prev_data);
                end
            end
            if (bus.o_valid === 1'b1 && !bus.i_stall) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_beat cycle %0d got d=%h exp none", cyc, bus.o_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus.o_data !== exp_b || bus.o_last !== (beat_idx == BEATS - 1)) begin
                        errors++;
                        $display("FAIL rand_beat cycle %0d got d=%h l=%b exp d=%h l=%b",
                                 cyc, bus.o_data, bus.o_last, exp_b, (beat_idx == BEATS - 1));
                    end
                end
                if (bus.o_last === 1'b1) lasts++;
                beat_idx = (beat_idx == BEATS - 1) ? 0 : beat_idx + 1;
            end
            prev_hold = (bus.o_valid === 1'b1) && bus.i_stall;
            prev_data = bus.o_data;
            if (bus.i_valid && bus.o_stall === 1'b0) begin
                for (int k = 0; k < BEATS; k++) exp_q.push_back(beat_of(word, k));
                pending = 1'b0;
                sent++;
            end
        end
        bus.i_valid = 1'b0;
        bus.i_stall = 1'b0;
        checks++;
        if (cyc >= 20000) begin
            errors++;
            $display("FAIL rand_timeout words %0d pending beats %0d exp 200 and 0", sent, exp_q.size());
        end
        checks++;
        if (lasts != 200) begin
            errors++;
            $display("FAIL rand_last_count got %0d exp 200", lasts);
        end
    endtask

    // Reset after the second beat drops the rest; next word starts at beat 0.
    task automatic test_reset_mid_word();
        logic [W-1:0] wc;
        logic [W-1:0] wd;
        wc = 128'hC0000003_C0000002_C0000001_C0000000;
        wd = 128'hD0000003_D0000002_D0000001_D0000000;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = wc;
        bus.i_stall = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1;
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== beat_of(wc, k)) begin
                errors++;
                $display("FAIL midrst_pre beat %0d got v=%b d=%h exp v=1 d=%h",
                         k, bus.o_valid, bus.o_data, beat_of(wc, k));
            end
        end
        @(negedge clk);
        rst_n       = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = wd;
        #1;
        checks++;
        if (bus.o_stall !== 1'b1) begin
            errors++;
            $display("FAIL midrst_stall got %b exp 1", bus.o_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0 || bus.o_stall !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after valid/last/stall got %b%b%b exp 000",
                     bus.o_valid, bus.o_last, bus.o_stall);
        end
        for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1;
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== beat_of(wd, k) ||
                bus.o_last !== (k == BEATS - 1)) begin
                errors++;
                $display("FAIL midrst_next beat %0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         k, bus.o_valid, bus.o_data, bus.o_last, beat_of(wd, k), (k == BEATS - 1));
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drain valid got %b exp 0", bus.o_valid);
        end
    endtask

    // BEATS=1 instance with toggling stall behaves as a one-deep register.
    task automatic test_beats1();
        logic         m_valid;
        logic [N-1:0] m_data;
        logic         stall_exp;
        logic         cons;
        logic         acc;
        int           sent;
        int           seen;
        int           cyc;
        m_valid = 1'b0;
        m_data  = '0;
        sent    = 0;
        seen    = 0;
        cyc     = 0;
        while ((sent < 20 || m_valid) && cyc < 200) begin
            @(negedge clk);
            bus1.i_stall = cyc[0];
            bus1.i_valid = (sent < 20);
            bus1.i_data  = 32'hB1000000 + 32'(sent);
            cyc++;
            #1;
            stall_exp = m_valid & bus1.i_stall;
            checks++;
            if (bus1.o_valid !== m_valid || bus1.o_stall !== stall_exp) begin
                errors++;
                $display("FAIL b1_ctrl cycle %0d got v=%b s=%b exp v=%b s=%b",
                         cyc, bus1.o_valid, bus1.o_stall, m_valid, stall_exp);
            end
            if (m_valid) begin
                checks++;
                if (bus1.o_data !== m_data || bus1.o_last !== 1'b1) begin
                    errors++;
                    $display("FAIL b1_data cycle %0d got d=%h l=%b exp d=%h l=1",
                             cyc, bus1.o_data, bus1.o_last, m_data);
                end
            end
            cons = m_valid & ~bus1.i_stall;
            acc  = bus1.i_valid & ~stall_exp;
            if (cons) seen++;
            if (acc) begin
                m_valid = 1'b1;
                m_data  = bus1.i_data;
                sent++;
            end else if (cons) begin
                m_valid = 1'b0;
            end
        end
        bus1.i_valid = 1'b0;
        bus1.i_stall = 1'b0;
        checks++;
        if (seen != 20 || cyc >= 200) begin
            errors++;
            $display("FAIL b1_count got %0d words in %0d cycles exp 20 before 200", seen, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_random_stall();
        test_reset_mid_word();
        test_beats1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
